// File: rtl/mux_scan_sequencer.sv
// ============================================================================
// mux_scan_sequencer: drives a WIDTH:1 mux tree and streams its output serially.
// Optional even-parity trailer beat when MUXSEQ_PARITY_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_scan_sequencer #(
  parameter int WIDTH     = 32,
  parameter int SEL_W     = 5,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] word_in_i,
  output logic [WIDTH-1:0] mux_in_o,
  output logic [SEL_W-1:0] sel_o,
  input  logic             mux_out_i,
  output logic             ser_bit_o,
  output logic             ser_valid_o,
  input  logic             ser_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [SEL_W-1:0] C_SEL_LO    = '0;
  localparam logic [SEL_W-1:0] C_SEL_HI    = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] C_SEL_FIRST = MSB_FIRST ? C_SEL_HI : C_SEL_LO;
  localparam logic [SEL_W-1:0] C_SEL_LAST  = MSB_FIRST ? C_SEL_LO : C_SEL_HI;

`ifdef MUXSEQ_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_DONE   = 2'd2,
    S_PARITY = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] mux_in_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic             ser_valid_q;
  logic             busy_q;
  logic             done_q;
`ifdef MUXSEQ_PARITY_EN
  logic             acc_q;
`endif

  always_comb begin
    sel_d = MSB_FIRST ? (sel_q - 1'b1) : (sel_q + 1'b1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mux_in_q    <= '0;
      sel_q       <= '0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MUXSEQ_PARITY_EN
      acc_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            mux_in_q    <= word_in_i;
            sel_q       <= C_SEL_FIRST;
            ser_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_SCAN;
`ifdef MUXSEQ_PARITY_EN
            acc_q       <= 1'b0;
`endif
          end
        end
        S_SCAN: begin
          if (ser_ready_i) begin
`ifdef MUXSEQ_PARITY_EN
            acc_q <= acc_q ^ mux_out_i;
`endif
            // Select parks on the last channel; it never wraps.
            if (sel_q == C_SEL_LAST) begin
`ifdef MUXSEQ_PARITY_EN
              state_q     <= S_PARITY;
`else
              state_q     <= S_DONE;
              ser_valid_q <= 1'b0;
              done_q      <= 1'b1;
`endif
            end else begin
              sel_q <= sel_d;
            end
          end
        end
`ifdef MUXSEQ_PARITY_EN
        S_PARITY: begin
          if (ser_ready_i) begin
            state_q     <= S_DONE;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          ser_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign mux_in_o    = mux_in_q;
  assign sel_o       = sel_q;
  assign ser_valid_o = ser_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
`ifdef MUXSEQ_PARITY_EN
  assign ser_bit_o   = ser_valid_q & ((state_q == S_PARITY) ? acc_q : mux_out_i);
`else
  assign ser_bit_o   = ser_valid_q & mux_out_i;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
// ============================================================================
// tb_mux_scan_sequencer: LSB-first and MSB-first instances run in lockstep
// against a bit-list reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mux_scan_sequencer;

  localparam int WIDTH = 32;
  localparam int SEL_W = 5;
`ifdef MUXSEQ_PARITY_EN
  localparam int NBEATS = WIDTH + 1;
`else
  localparam int NBEATS = WIDTH;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, start, ser_ready;
  logic [WIDTH-1:0] word_in;
  logic [WIDTH-1:0] mux_in_l, mux_in_m;
  logic [SEL_W-1:0] sel_l, sel_m;
  logic             mo_l, mo_m, bit_l, bit_m, val_l, val_m;
  logic             busy_l, busy_m, done_l, done_m;

  // Behavioural mux tree for each instance.
  assign mo_l = mux_in_l[sel_l];
  assign mo_m = mux_in_m[sel_m];

  mux_scan_sequencer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .start_i(start), .word_in_i(word_in),
    .mux_in_o(mux_in_l), .sel_o(sel_l), .mux_out_i(mo_l), .ser_bit_o(bit_l),
    .ser_valid_o(val_l), .ser_ready_i(ser_ready), .busy_o(busy_l), .done_o(done_l)
  );

  mux_scan_sequencer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .start_i(start), .word_in_i(word_in),
    .mux_in_o(mux_in_m), .sel_o(sel_m), .mux_out_i(mo_m), .ser_bit_o(bit_m),
    .ser_valid_o(val_m), .ser_ready_i(ser_ready), .busy_o(busy_m), .done_o(done_m)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_val_l"}, 32'(val_l), 32'd0);
    chk({tag, "_val_m"}, 32'(val_m), 32'd0);
    chk({tag, "_bit_l"}, 32'(bit_l), 32'd0);
    chk({tag, "_bit_m"}, 32'(bit_m), 32'd0);
    chk({tag, "_busy_l"}, 32'(busy_l), 32'd0);
    chk({tag, "_busy_m"}, 32'(busy_m), 32'd0);
    chk({tag, "_done_l"}, 32'(done_l), 32'd0);
    chk({tag, "_done_m"}, 32'(done_m), 32'd0);
    chk({tag, "_sel_l"}, 32'(sel_l), 32'd0);
    chk({tag, "_sel_m"}, 32'(sel_m), 32'd0);
    chk({tag, "_muxin_l"}, mux_in_l, 32'd0);
    chk({tag, "_muxin_m"}, mux_in_m, 32'd0);
  endtask

  // mode: 0 ready always high, 1 ready toggles 1,0,..., 2 ready random.
  // restart_at: cycle in which a spurious start with all-ones word is driven.
  // abort_at: cycle in which reset is asserted.
  task automatic run_word(input logic [WIDTH-1:0] w, input int mode,
                          input int restart_at, input int abort_at);
    bit el [0:WIDTH];
    bit em [0:WIDTH];
    int k, done_cycle, idx;
    bit finished;
    for (int i = 0; i < WIDTH; i++) begin
      el[i] = w[i];
      em[i] = w[WIDTH-1-i];
    end
    el[WIDTH] = ^w;
    em[WIDTH] = ^w;
    k = 0;
    done_cycle = -10;
    finished = 1'b0;
    start   = 1'b1;
    word_in = w;
    for (int c = 1; c < 400 && !finished; c++) begin
      @(posedge clk); #1;
      start   = (c == restart_at);
      word_in = (c == restart_at) ? '1 : WIDTH'($urandom);
      rst_n   = (c != abort_at);
      if (mode == 0)      ser_ready = 1'b1;
      else if (mode == 1) ser_ready = (c % 2 == 1);
      else                ser_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      chk("valid_l", 32'(val_l), 32'(k < NBEATS));
      chk("valid_m", 32'(val_m), 32'(k < NBEATS));
      chk("busy_l", 32'(busy_l), 32'(k < NBEATS || c == done_cycle));
      chk("busy_m", 32'(busy_m), 32'(k < NBEATS || c == done_cycle));
      chk("done_l", 32'(done_l), 32'(c == done_cycle));
      chk("done_m", 32'(done_m), 32'(c == done_cycle));
      if (k < NBEATS) begin
        idx = (k < WIDTH) ? k : WIDTH - 1;
        chk("bit_l", 32'(bit_l), 32'(el[k]));
        chk("bit_m", 32'(bit_m), 32'(em[k]));
        chk("sel_l", 32'(sel_l), 32'(idx));
        chk("sel_m", 32'(sel_m), 32'(WIDTH - 1 - idx));
        chk("muxin_l", mux_in_l, w);
        chk("muxin_m", mux_in_m, w);
        if (ser_ready && c != abort_at) begin
          k++;
          if (k == NBEATS) done_cycle = c + 1;
        end
      end
      if (c == abort_at) begin
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("abort");
        repeat (3) begin
          @(negedge clk);
          chk("abort_nodone_l", 32'(done_l), 32'd0);
          chk("abort_nodone_m", 32'(done_m), 32'd0);
        end
        finished = 1'b1;
      end else if (c == done_cycle + 1) begin
        finished = 1'b1;
      end
    end
    if (!finished) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    ser_ready = 1'b0;
    word_in   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy_l), 32'd0);

    // start coincident with reset: reset wins.
    @(posedge clk); #1;
    rst_n   = 1'b0;
    start   = 1'b1;
    word_in = 32'h0000_0005;
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_vs_start");
    @(negedge clk);
    chk("rst_vs_start_busy2", 32'(busy_l), 32'd0);

    run_word(32'h0000_0001, 0, -1, -1);
    run_word(32'h0000_00E7, 1, -1, -1);
    run_word(32'h0000_0802, 0, 5, -1);
    run_word(32'h0000_0005, 0, -1, 10);
    run_word(32'h0000_0001, 0, -1, -1);
    run_word(32'h8000_0802, 0, -1, -1);
    run_word(32'h0000_0005, 0, -1, -1);
    run_word(32'h0000_0007, 2, -1, -1);
    run_word(32'hFFFF_FFFF, 1, -1, -1);
    run_word($urandom, 0, NBEATS + 1, -1);
    for (int i = 0; i < 8; i++) begin
      run_word($urandom, 2, $urandom_range(2, 30), -1);
    end
    run_word($urandom, 2, -1, $urandom_range(3, 30));
    run_word($urandom, 0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
